// File: rtl/uart_read_arbiter_if.sv
// uart_read_arbiter_if: requester, UART read-port and tagged return signals of the UART read arbiter.
interface uart_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W = 4
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       gnt;
    logic                     uart_re;
    logic [7:0]               uart_data;
    logic [7:0]               rd_data;
    logic                     rd_valid;
    logic [IW-1:0]            rd_id;
    logic                     busy;
    modport master (
        output req, req_len, uart_data,
        input  gnt, uart_re, rd_data, rd_valid, rd_id, busy
    );
    modport slave (
        input  req, req_len, uart_data,
        output gnt, uart_re, rd_data, rd_valid, rd_id, busy
    );
endinterface

// File: rtl/uart_read_arbiter.sv
// uart_read_arbiter: shares the UART read port among requesters, issuing bursts and tagging returned bytes.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W = 4,
    parameter int LAT = 2
) (
    input logic clk,
    input logic rst,
    uart_read_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (LEN_W + 1 > $clog2(LAT + 1)) ? LEN_W + 1 : $clog2(LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] id, win, j, ptr;
    logic [LEN_W-1:0] lens [NUM_REQ];
    logic [LAT-1:0] sr_v;
    logic [IW-1:0] sr_id [LAT];
    logic last;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign lens[g] = bus.req_len[g*LEN_W +: LEN_W];
    end

    // Scan downwards so the first set bit at or after ptr is the one that sticks.
    always_comb begin
        win = '0;
        j = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NUM_REQ);
            if (bus.req[j]) win = j;
        end
    end

    assign last = cnt == CW'(1);

    // cnt counts remaining beats in ISSUE and remaining latency cycles in DRAIN.
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        case (state)
            IDLE: if (|bus.req) begin
                state_n = ISSUE;
                cnt_n = (lens[win] == '0) ? CW'(1 << LEN_W) : CW'(lens[win]);
            end
            ISSUE: begin
                state_n = last ? DRAIN : ISSUE;
                cnt_n = last ? CW'(LAT) : cnt - 1'b1;
            end
            DRAIN: begin
                state_n = last ? IDLE : DRAIN;
                cnt_n = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            id <= '0;
            sr_v <= '0;
            for (int i = 0; i < LAT; i++) sr_id[i] <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (state == IDLE && |bus.req) id <= win;
            sr_v <= LAT'({sr_v, bus.uart_re});
            sr_id[0] <= id;
            for (int i = 1; i < LAT; i++) sr_id[i] <= sr_id[i-1];
        end
    end

`ifdef UART_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else if (state == DRAIN && last) ptr <= (id == IW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    end
`endif

    assign bus.uart_re = state == ISSUE;
    assign bus.busy = state != IDLE;
    assign bus.gnt = bus.busy ? NUM_REQ'(1) << id : '0;
    assign bus.rd_data = bus.uart_data;
    assign bus.rd_valid = sr_v[LAT-1];
    assign bus.rd_id = sr_id[LAT-1];
endmodule

// File: tb/tb_uart_read_arbiter.sv
// tb_uart_read_arbiter: timeline-based reference model plus directed literal checks and random traffic.
module tb_uart_read_arbiter;
    localparam int NUM_REQ = 4, LEN_W = 4, LAT = 2, IW = $clog2(NUM_REQ), MAXC = 8192;
    logic clk = 0, rst = 1, uart_rst = 1;
    int checks = 0, errors = 0, cyc = 0;
    always #5 clk = ~clk;

    uart_read_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus();
    uart_read_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    // UART receive buffer: 16 fixed bytes, wrapping read index, LAT-cycle read latency
    logic [7:0] ubuf [16] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18,
                              8'h29, 8'h3A, 8'h4B, 8'h5C, 8'h6D, 8'h7E, 8'h8F, 8'h90};
    logic [3:0] u_idx;
    logic [7:0] u_p [LAT];
    always @(posedge clk) begin
        if (uart_rst) u_idx <= 0;
        else if (bus.uart_re) u_idx <= u_idx + 1;
        u_p[0] <= ubuf[u_idx];
        for (int i = 1; i < LAT; i++) u_p[i] <= u_p[i-1];
    end
    assign bus.uart_data = u_p[LAT-1];

    // Reference model: a per-cycle timeline of what each output must be
    bit [NUM_REQ-1:0] e_gnt [MAXC];
    bit e_re [MAXC];
    bit e_v [MAXC];
    logic [IW-1:0] e_id [MAXC];
    logic [7:0] e_data [MAXC];
    int m_idle = 0, m_ptr = 0, m_rcnt = 0;
    logic [15:0] lg [$];
    int re_n, gnt_n [NUM_REQ];

    function automatic int pick(logic [NUM_REQ-1:0] r, int p);
        for (int k = 0; k < NUM_REQ; k++) if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return 0;
    endfunction

    always @(negedge clk) begin
        int w, n;
        if (rst) begin
            for (int i = cyc; i < cyc + 64 && i < MAXC; i++) begin
                e_gnt[i] = 0; e_re[i] = 0; e_v[i] = 0;
            end
            m_idle = cyc + 1;
            m_ptr = 0;
        end
        if (uart_rst) m_rcnt = 0;
        if (e_re[cyc]) begin
            e_data[cyc + LAT] = ubuf[m_rcnt % 16];
            m_rcnt++;
        end
        checks++;
        if (bus.gnt !== e_gnt[cyc] || bus.uart_re !== e_re[cyc] || bus.busy !== (e_gnt[cyc] != 0) ||
            bus.rd_valid !== e_v[cyc] || (e_v[cyc] && (bus.rd_id !== e_id[cyc] || bus.rd_data !== e_data[cyc]))) begin
            errors++;
            $display("FAIL cycle %0d: got gnt=%b re=%b busy=%b v=%b id=%0d data=%h, required gnt=%b re=%b v=%b id=%0d data=%h",
                     cyc, bus.gnt, bus.uart_re, bus.busy, bus.rd_valid, bus.rd_id, bus.rd_data,
                     e_gnt[cyc], e_re[cyc], e_v[cyc], e_id[cyc], e_data[cyc]);
        end
        if (bus.rd_valid) lg.push_back({8'(bus.rd_id), bus.rd_data});
        if (bus.uart_re) re_n++;
        for (int i = 0; i < NUM_REQ; i++) if (bus.gnt[i]) gnt_n[i]++;
        if (!rst && cyc >= m_idle && bus.req != 0) begin
            w = pick(bus.req, m_ptr);
            n = int'(bus.req_len[w*LEN_W +: LEN_W]);
            if (n == 0) n = 1 << LEN_W;
            for (int i = 1; i <= n + LAT; i++) e_gnt[cyc + i] = NUM_REQ'(1) << w;
            for (int i = 1; i <= n; i++) begin
                e_re[cyc + i] = 1;
                e_v[cyc + i + LAT] = 1;
                e_id[cyc + i + LAT] = IW'(w);
            end
            m_idle = cyc + n + LAT + 1;
`ifdef UART_ARB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (w + 1) % NUM_REQ;
`endif
        end
        cyc++;
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_log();
        lg.delete();
        re_n = 0;
        for (int i = 0; i < NUM_REQ; i++) gnt_n[i] = 0;
    endtask

    task automatic do_reset(bit uart);
        rst = 1; uart_rst = uart; bus.req = '0;
        tick(2);
        rst = 0; uart_rst = 0;
    endtask

    task automatic set_len(int i, int l);
        bus.req_len[i*LEN_W +: LEN_W] = LEN_W'(l);
    endtask

    task automatic wait_gnt(int i, string name);
        int n = 0;
        while (!bus.gnt[i] && n < 40) begin tick(); n++; end
        chk(name, int'(bus.gnt[i]), 1);
    endtask

    initial begin
        int n0, n1;
        bus.req = '0; bus.req_len = '0;
        tick(2);
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_re", int'(bus.uart_re), 0);
        chk("rst_valid", int'(bus.rd_valid), 0);
        chk("rst_id", int'(bus.rd_id), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst = 0; uart_rst = 0;
        tick(2);
        // single len-3 burst from requester 1
        clr_log(); set_len(1, 3); bus.req = 4'b0010; tick(); bus.req = 0; tick(10);
        chk("t1_count", lg.size(), 3);
        chk("t1_b0", int'(lg[0]), 'h01A1);
        chk("t1_b1", int'(lg[1]), 'h01B2);
        chk("t1_b2", int'(lg[2]), 'h01C3);
        chk("t1_re", re_n, 3);
        chk("t1_gnt1", gnt_n[1], 5);
        // simultaneous requests 0 and 2 from rr_ptr=0
        do_reset(1); clr_log();
        set_len(0, 1); set_len(2, 1);
        bus.req = 4'b0101; tick(); bus.req = 4'b0100;
        wait_gnt(2, "t2_gnt2");
        bus.req = 0; tick(8);
        chk("t2_count", lg.size(), 2);
        chk("t2_b0", int'(lg[0]), 'h00A1);
        chk("t2_b1", int'(lg[1]), 'h02B2);
        // requester 0 held continuously must not starve requester 2
        do_reset(1); clr_log();
        bus.req = 4'b0101;
        wait_gnt(2, "t2b_gnt2");
        bus.req = 4'b0001; tick(10); bus.req = 0; tick(6);
        chk("t2b_first", int'(lg[0][15:8]), 0);
        chk("t2b_second", int'(lg[1][15:8]), 2);
        // len 0 = 16 beats, then wrap of UART index
        do_reset(1); clr_log();
        set_len(3, 0); bus.req = 4'b1000; tick(); bus.req = 0; tick(22);
        set_len(3, 1); bus.req = 4'b1000; tick(); bus.req = 0; tick(6);
        chk("t3_count", lg.size(), 17);
        chk("t3_first", int'(lg[0]), 'h03A1);
        chk("t3_last16", int'(lg[15]), 'h0390);
        chk("t3_wrap", int'(lg[16]), 'h03A1);
        chk("t3_re", re_n, 17);
        // reset during second beat of a len-4 burst
        do_reset(1); clr_log();
        set_len(1, 4); bus.req = 4'b0010; tick(); bus.req = 0; tick();
        rst = 1; #1;
        chk("t4_gnt", int'(bus.gnt), 0);
        chk("t4_re", int'(bus.uart_re), 0);
        chk("t4_valid", int'(bus.rd_valid), 0);
        chk("t4_id", int'(bus.rd_id), 0);
        chk("t4_busy", int'(bus.busy), 0);
        tick(); rst = 0; tick(6);
        chk("t4_no_valid", lg.size(), 0);
        set_len(1, 1); set_len(3, 1); bus.req = 4'b1010; tick(); bus.req = 0; tick(6);
        chk("t4_next_count", lg.size(), 1);
        chk("t4_next", int'(lg[0]), 'h01B2);
        // requesters 0 and 1 held continuously
        do_reset(1); clr_log();
        set_len(0, 2); set_len(1, 2); bus.req = 4'b0011; tick(60); bus.req = 0; tick(6);
        n0 = 0; n1 = 0;
        foreach (lg[i]) begin
            if (lg[i][15:8] == 0) n0++;
            if (lg[i][15:8] == 1) n1++;
        end
        chk("t5_n0", int'(n0 > 0), 1);
`ifdef UART_ARB_FIXED_PRIO_EN
        chk("t5_n1_none", n1, 0);
        chk("t5_gnt1_none", gnt_n[1], 0);
`else
        chk("t5_n1", int'(n1 > 0), 1);
`endif
        // random traffic with occasional reset
        do_reset(1);
        for (int c = 0; c < 2500; c++) begin
            bus.req = NUM_REQ'($urandom & $urandom);
            bus.req_len = (NUM_REQ*LEN_W)'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1; bus.req = '0; tick($urandom_range(1, 2)); rst = 0;
            end
            tick();
        end
        bus.req = 0; tick(30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_read_arbiter.md
# uart_read_arbiter

Round-robin arbiter that shares the single read port of the UART receive buffer among up to NUM_REQ requesters. It grants one requester at a time, issues a burst of 1–16 read-enable pulses to the UART, and tracks the UART's fixed two-cycle read latency. Each returned byte is tagged with the owning requester's ID. It sits between the UART buffer module and the consumer blocks (protocol parsers, debug readout) that fetch bytes from it.

## Interface
- NUM_REQ, 4, number of requesters (2–8)
- LEN_W, 4, burst-length field width per requester
- LAT, 2, cycles from the UART read-enable being high to the byte appearing on the UART data output
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester request, level
- req_len  input  NUM_REQ*LEN_W  packed burst lengths; requester i uses bits [i*LEN_W +: LEN_W]; value 0 encodes 16
- gnt  output  NUM_REQ  one-hot grant, held for the whole burst including drain
- uart_re  output  1  read enable to the UART
- uart_data  input  8  UART data output
- rd_data  output  8  returned byte, direct pass-through of uart_data
- rd_valid  output  1  rd_data holds a byte belonging to rd_id
- rd_id  output  $clog2(NUM_REQ)  owner of the current rd_data
- busy  output  1  high in ISSUE and DRAIN

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - If any req bit is set, select a winner by round-robin, starting from the requester at rr_ptr.
  - Register the winner's gnt bit, its ID, and its burst length (0 becomes 16). Go to ISSUE.
- ISSUE:
  - uart_re is high every cycle. The beat counter decrements each cycle.
  - After the final beat, go to DRAIN. Exactly len re pulses are issued.
- DRAIN:
  - uart_re is low. Stay LAT cycles so the last byte returns, then go to IDLE.
  - On leaving DRAIN, rr_ptr becomes winner+1 mod NUM_REQ.
- A burst is committed once granted. Dropping req or changing req_len mid-burst has no effect on it.
- Valid/ID pipeline:
  - An LAT-deep shift register carries (uart_re, gnt ID).
  - rd_valid and rd_id are the tail of that shift register. rd_data is uart_data, unregistered.
- The arbiter never resets the UART read index. Byte order is whatever the UART's wrapping index yields.
- Reset, including mid-burst: immediately go to IDLE.
  - gnt=0, uart_re=0, rd_valid=0, rd_id=0, busy=0.
  - rr_ptr=0 and the shift register is cleared.
  - In-flight bytes are discarded.

## Timing
- req first seen high in cycle t, with the arbiter in IDLE:
  - gnt and uart_re go high in cycle t+1.
  - The first rd_valid is in cycle t+1+LAT, i.e. t+3.
- Burst of length N:
  - uart_re is high for cycles t+1 … t+N.
  - rd_valid is high for cycles t+3 … t+N+2. busy falls after cycle t+N+LAT.
- Gap between bursts: the FSM returns to IDLE for one cycle before re-arbitrating. uart_re is low for at least LAT+1 cycles between bursts.
- Simultaneous requests in the same cycle: the first set bit at or after rr_ptr (wrapping) wins.
- req with no grant is not an error. A requester waits while busy, and its request is honoured at the next IDLE.
- At most one gnt bit is set in any cycle. gnt=0 whenever the FSM is in IDLE.

## Configuration
- UART_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins. rr_ptr is not implemented and is treated as 0.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- UART freshly reset; req[1]=1 with len 3 for one cycle → uart_re high for 3 cycles. rd_valid is high for 3 cycles with rd_data A1, B2, C3 and rd_id=1. gnt[1] is held for 5 cycles total.
- req[0] and req[2] raised in the same cycle, both len 1, rr_ptr=0 → requester 0 is served first (data A1), then requester 2 (data B2, rd_id=2).
  - Repeat with req[0] held continuously: requester 2 must still be served, with no starvation.
- req[3] with len 0 → 16 re pulses and bytes A1 … 90. A following len 1 burst returns A1, confirming UART index wrap.
- rst pulsed during the second beat of a len 4 burst → all outputs are 0 during reset with no further rd_valid. The next request starts a fresh grant from rr_ptr=0.
- Build with UART_ARB_FIXED_PRIO_EN; hold req[0] and req[1] high continuously → requester 0 is granted on every burst and requester 1 is never granted.
